if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage LoongArch pipeline. It sits at the producer end of the IF→ID interface and the consumer end of the branch bus driven by ID.
- Holds the fetch PC and issues requests to a synchronous instruction SRAM with 1-cycle read latency.
- Buffers the returned instruction across ID back-pressure.
- Applies branch redirects from BR_BUS and squashes the wrong-path instruction.

---
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the fetch PC, drives a 1-cycle-latency instruction SRAM,
// buffers the returned word across ID stalls and applies ID branch redirects.
// Optional macro IF_ADEF_EN adds IFreg_adef (misaligned-fetch flag, nop injected).
`ifndef BR_BUS_LEN
`define BR_BUS_LEN 33
`endif

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ID_allow_in,
  input  logic [`BR_BUS_LEN-1:0] BR_BUS,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_we,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic                   IF_ready_go,
  output logic                   IF_allow_in,
  output logic                   IFreg_valid,
  output logic [31:0]            IFreg_inst,
  output logic [31:0]            IFreg_pc
`ifdef IF_ADEF_EN
  ,
  output logic                   IFreg_adef
`endif
);

  localparam logic [31:0] NOP_INST = 32'h03400000;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;

  logic        br_taken_s;
  logic [31:0] br_target_s;
  logic        to_fs_valid_s;
  logic [31:0] nextpc_s;
  logic        ready_go_s;
  logic        allow_in_s;
  logic        fetch_ok_s;
  logic        handoff_s;

  assign {br_target_s, br_taken_s} = BR_BUS;

  assign to_fs_valid_s = ~reset;
  assign ready_go_s    = 1'b1;
  assign nextpc_s      = br_taken_s ? br_target_s : (fs_pc_q + 32'd4);
  assign allow_in_s    = ~fs_valid_q | (ready_go_s & ID_allow_in);
  assign handoff_s     = fs_valid_q & ID_allow_in;

`ifdef IF_ADEF_EN
  // Misaligned fetches never reach the SRAM; the fault is reported alongside a nop.
  assign fetch_ok_s = (nextpc_s[1:0] == 2'b00);
`else
  assign fetch_ok_s = 1'b1;
`endif

  assign inst_sram_en    = to_fs_valid_s & (allow_in_s | br_taken_s) & fetch_ok_s;
  assign inst_sram_we    = 4'b0000;
  assign inst_sram_addr  = nextpc_s;
  assign inst_sram_wdata = 32'h00000000;

  assign IF_ready_go = ready_go_s;
  assign IF_allow_in = allow_in_s;
  assign IFreg_pc    = fs_pc_q;
  // The word in IF while ID resolves a taken branch is wrong-path: squash it.
  assign IFreg_valid = fs_valid_q & ~br_taken_s;

`ifdef IF_ADEF_EN
  assign IFreg_adef = fs_valid_q & (fs_pc_q[1:0] != 2'b00);
  assign IFreg_inst = IFreg_adef ? NOP_INST
                    : (inst_buf_valid_q ? inst_buf_q : inst_sram_rdata);
`else
  assign IFreg_inst = inst_buf_valid_q ? inst_buf_q : inst_sram_rdata;
`endif

  // Next-state for fetch PC/valid and the stall buffer; redirect has top priority.
  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;

    if (br_taken_s) begin
      fs_pc_d    = br_target_s;
      fs_valid_d = 1'b1;
    end else if (allow_in_s) begin
      fs_pc_d    = nextpc_s;
      fs_valid_d = to_fs_valid_s;
    end else begin
      fs_pc_d    = fs_pc_q;
      fs_valid_d = fs_valid_q;
    end

    // The SRAM output is only valid one cycle after a request, so capture it on the first stall cycle.
    if (br_taken_s) begin
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q & ~ID_allow_in & ~inst_buf_valid_q) begin
      inst_buf_d       = inst_sram_rdata;
      inst_buf_valid_d = 1'b1;
    end else if (handoff_s) begin
      inst_buf_valid_d = 1'b0;
    end else begin
      inst_buf_valid_d = inst_buf_valid_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_q       <= 32'h00000000;
      inst_buf_valid_q <= 1'b0;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, stall buffering, redirects,
// mid-cycle async reset, misaligned target and PC wrap-around.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_allow_in;
  logic [32:0] BR_BUS;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        IF_ready_go;
  logic        IF_allow_in;
  logic        IFreg_valid;
  logic [31:0] IFreg_inst;
  logic [31:0] IFreg_pc;
`ifdef IF_ADEF_EN
  logic        IFreg_adef;
`endif

  logic [31:0] sram_q = 32'h00000000;
  logic        garble;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk             (clk),
    .reset           (reset),
    .ID_allow_in     (ID_allow_in),
    .BR_BUS          (BR_BUS),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .IF_ready_go     (IF_ready_go),
    .IF_allow_in     (IF_allow_in),
    .IFreg_valid     (IFreg_valid),
    .IFreg_inst      (IFreg_inst),
    .IFreg_pc        (IFreg_pc)
`ifdef IF_ADEF_EN
    ,
    .IFreg_adef      (IFreg_adef)
`endif
  );

  // Instruction memory contents: one marked word, everything else is the inverted address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1c000008) return 32'h02800421;
    return ~a;
  endfunction

  // Synchronous SRAM with 1-cycle read latency; garble models a stalled, unreliable output.
  always @(posedge clk) begin
    if (inst_sram_en) sram_q <= mem_word(inst_sram_addr);
  end
  assign inst_sram_rdata = garble ? 32'hdeadbeef : sram_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    ID_allow_in = 1'b1;
    BR_BUS      = 33'd0;
    garble      = 1'b0;
    #2;
    chk("rst_valid",    IFreg_valid,    32'd0);
    chk("rst_en",       inst_sram_en,   32'd0);
    chk("rst_pc",       IFreg_pc,       32'h1bfffffc);
    chk("rst_allow",    IF_allow_in,    32'd1);
    chk("tie_we",       inst_sram_we,   32'd0);
    chk("tie_wdata",    inst_sram_wdata, 32'd0);
    chk("tie_rgo",      IF_ready_go,    32'd1);
    @(posedge clk);
    tick();
    reset = 1'b0;
    #3;
    // cycle 0: first request
    chk("c0_en",   inst_sram_en,   32'd1);
    chk("c0_addr", inst_sram_addr, 32'h1c000000);
    chk("c0_valid", IFreg_valid,   32'd0);
    tick(); #3;
    chk("c1_valid", IFreg_valid,   32'd1);
    chk("c1_pc",    IFreg_pc,      32'h1c000000);
    chk("c1_inst",  IFreg_inst,    32'he3ffffff);
    chk("c1_addr",  inst_sram_addr, 32'h1c000004);
    tick(); #3;
    chk("c2_pc",    IFreg_pc,      32'h1c000004);
    chk("c2_inst",  IFreg_inst,    32'he3fffffb);
    // stall: 3 cycles of ID back-pressure at 0x1c000008
    tick();
    ID_allow_in = 1'b0;
    #3;
    chk("st0_pc",    IFreg_pc,     32'h1c000008);
    chk("st0_inst",  IFreg_inst,   32'h02800421);
    chk("st0_en",    inst_sram_en, 32'd0);
    chk("st0_allow", IF_allow_in,  32'd0);
    for (int i = 1; i < 3; i++) begin
      tick();
      garble = 1'b1;
      #3;
      chk("st_inst",  IFreg_inst,   32'h02800421);
      chk("st_en",    inst_sram_en, 32'd0);
      chk("st_pc",    IFreg_pc,     32'h1c000008);
      chk("st_valid", IFreg_valid,  32'd1);
    end
    tick();
    ID_allow_in = 1'b1;
    #3;
    chk("rel_inst", IFreg_inst,     32'h02800421);
    chk("rel_en",   inst_sram_en,   32'd1);
    chk("rel_addr", inst_sram_addr, 32'h1c00000c);
    tick();
    garble = 1'b0;
    #3;
    chk("c7_pc",   IFreg_pc,   32'h1c00000c);
    chk("c7_inst", IFreg_inst, 32'he3fffff3);
    // branch from 0x1c000010 to 0x1c000100
    tick();
    BR_BUS = {32'h1c000100, 1'b1};
    #3;
    chk("br_pc",    IFreg_pc,       32'h1c000010);
    chk("br_valid", IFreg_valid,    32'd0);
    chk("br_en",    inst_sram_en,   32'd1);
    chk("br_addr",  inst_sram_addr, 32'h1c000100);
    tick();
    BR_BUS = 33'd0;
    #3;
    chk("bt_pc",    IFreg_pc,    32'h1c000100);
    chk("bt_valid", IFreg_valid, 32'd1);
    chk("bt_inst",  IFreg_inst,  32'he3fffeff);
    // branch while the stall buffer holds a word
    tick();
    ID_allow_in = 1'b0;
    #3;
    chk("bb0_inst", IFreg_inst, 32'he3fffefb);
    tick();
    BR_BUS = {32'h1c000200, 1'b1};
    garble = 1'b1;
    #3;
    chk("bb1_inst",  IFreg_inst,     32'he3fffefb);
    chk("bb1_valid", IFreg_valid,    32'd0);
    chk("bb1_en",    inst_sram_en,   32'd1);
    chk("bb1_addr",  inst_sram_addr, 32'h1c000200);
    tick();
    BR_BUS      = 33'd0;
    ID_allow_in = 1'b1;
    garble      = 1'b0;
    #3;
    chk("bb2_pc",    IFreg_pc,       32'h1c000200);
    chk("bb2_valid", IFreg_valid,    32'd1);
    chk("bb2_inst",  IFreg_inst,     32'he3fffdff);
    chk("bb2_addr",  inst_sram_addr, 32'h1c000204);
    // asynchronous reset between edges
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", IFreg_valid,  32'd0);
    chk("ar_en",    inst_sram_en, 32'd0);
    chk("ar_pc",    IFreg_pc,     32'h1bfffffc);
    chk("ar_allow", IF_allow_in,  32'd1);
    tick();
    reset = 1'b0;
    #3;
    chk("rr_addr",  inst_sram_addr, 32'h1c000000);
    chk("rr_en",    inst_sram_en,   32'd1);
    chk("rr_valid", IFreg_valid,    32'd0);
    tick(); #3;
    chk("rr1_pc",   IFreg_pc,   32'h1c000000);
    chk("rr1_inst", IFreg_inst, 32'he3ffffff);
    // misaligned branch target
    tick();
    BR_BUS = {32'h1c000102, 1'b1};
    #3;
    chk("ma_addr", inst_sram_addr, 32'h1c000102);
`ifdef IF_ADEF_EN
    chk("ma_en",   inst_sram_en,   32'd0);
`else
    chk("ma_en",   inst_sram_en,   32'd1);
`endif
    tick();
    BR_BUS = 33'd0;
    #3;
    chk("ma1_pc",    IFreg_pc,    32'h1c000102);
    chk("ma1_valid", IFreg_valid, 32'd1);
`ifdef IF_ADEF_EN
    chk("ma1_adef",  IFreg_adef,  32'd1);
    chk("ma1_inst",  IFreg_inst,  32'h03400000);
`else
    chk("ma1_inst",  IFreg_inst,  32'he3fffefd);
`endif
    // PC wrap-around modulo 2^32
    tick();
    BR_BUS = {32'hfffffffc, 1'b1};
    #3;
    chk("wr_addr", inst_sram_addr, 32'hfffffffc);
    tick();
    BR_BUS = 33'd0;
    #3;
    chk("wr1_pc",   IFreg_pc,       32'hfffffffc);
    chk("wr1_addr", inst_sram_addr, 32'h00000000);
    chk("wr1_inst", IFreg_inst,     32'h00000003);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
